float_align: RTL and testbench

Front-end operand alignment stage of the floating-point adder datapath. It accepts two packed IEEE-754 operands, unpacks them, orders them by magnitude and right-shifts the smaller mantissa to the larger exponent. While shifting, it produces the guard, round and sticky bits that the downstream normalize and round stages consume. It also emits the equal-exponent and equal-mantissa flags, effective-subtract and special-value flags that travel with the operation.

---
 rtl/float_pkg.sv | 35 +++
 rtl/float_sticky_shifter.sv | 70 +++++++
 rtl/float_align.sv | 151 +++++++++++++++
 tb/tb_float_align.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and constants for the float_align operand-alignment stage.
package float_pkg;

  localparam int N         = 24;
  localparam int EXP_W     = 8;
  localparam int OP_W      = N + EXP_W;
  localparam int VEC_W     = N + 2;
  localparam int SHIFT_CAP = N + 2;
  localparam int CNT_W     = $clog2(SHIFT_CAP + 1);

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [N-1:0]     mant;
  } unpacked_t;

  // Denormals get hidden bit 0 and effective exponent 1.
  function automatic unpacked_t unpack(input logic [OP_W-1:0] op);
    unpacked_t u;
    u.sign = op[OP_W-1];
    u.exp  = (op[OP_W-2 -: EXP_W] == '0) ? EXP_W'(1) : op[OP_W-2 -: EXP_W];
    u.mant = {op[OP_W-2 -: EXP_W] != '0, op[N-2:0]};
    return u;
  endfunction

endpackage

// File: rtl/float_sticky_shifter.sv
// {mant, G, R, S} right-shifter with shift count; serial by default,
// single-cycle barrel form when FLOAT_ALIGN_BARREL_EN is defined.
module float_sticky_shifter
  import float_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [N-1:0]     i_mant,
  input  logic [CNT_W-1:0] i_count,
  output logic [N-1:0]     o_mant,
  output logic             o_g,
  output logic             o_r,
  output logic             o_s,
  output logic             o_last
);

  logic [VEC_W-1:0] r_vec;
  logic             r_s;
  logic [CNT_W-1:0] r_count;

`ifdef FLOAT_ALIGN_BARREL_EN
  logic [VEC_W-1:0] w_lost;

  // Bits that fall off the bottom of {mant, G, R} feed the sticky bit.
  assign w_lost = r_vec & ~({VEC_W{1'b1}} << r_count);
  assign o_last = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec   <= '0;
      r_s     <= 1'b0;
      r_count <= '0;
    end else if (i_load) begin
      r_vec   <= {i_mant, 2'b00};
      r_s     <= 1'b0;
      r_count <= i_count;
    end else if (i_shift) begin
      r_vec   <= r_vec >> r_count;
      r_s     <= r_s | (|w_lost);
      r_count <= '0;
    end
  end
`else
  assign o_last = (r_count == CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec   <= '0;
      r_s     <= 1'b0;
      r_count <= '0;
    end else if (i_load) begin
      r_vec   <= {i_mant, 2'b00};
      r_s     <= 1'b0;
      r_count <= i_count;
    end else if (i_shift) begin
      r_vec   <= r_vec >> 1;
      r_s     <= r_s | r_vec[0];
      r_count <= r_count - 1'b1;
    end
  end
`endif

  assign o_mant = r_vec[VEC_W-1:2];
  assign o_g    = r_vec[1];
  assign o_r    = r_vec[0];
  assign o_s    = r_s;

endmodule

// File: rtl/float_align.sv
// FP adder front end: unpack, order by magnitude, align smaller mantissa with G/R/S.
// Build option FLOAT_ALIGN_BARREL_EN selects a one-cycle barrel shift instead of serial.
module float_align
  import float_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [OP_W-1:0]   i_op_a,
  input  logic [OP_W-1:0]   i_op_b,
  input  logic              i_sub,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_out_ready,
  output logic              o_valid,
  output logic [N-1:0]      o_mant_big,
  output logic [N-1:0]      o_mant_small,
  output logic              o_g,
  output logic              o_r,
  output logic              o_s,
  output logic [EXP_W-1:0]  o_common_exp,
  output logic              o_sign_big,
  output logic              o_eff_sub,
  output logic              o_exp_no_dif,
  output logic              o_mant_no_dif,
  output logic              o_is_nan,
  output logic              o_is_inf,
  output logic [1:0]        o_state
);

  // Handshake: input moves when i_valid && o_ready (IDLE only), result moves
  // when o_valid && i_out_ready (DONE only); result fields hold until then.
  state_t            r_state, w_state_nxt;
  logic              r_ready;
  logic [OP_W-1:0]   r_op_a, r_op_b;
  logic              r_sub;
  logic [N-1:0]      r_mant_big;
  logic [EXP_W-1:0]  r_common_exp;
  logic              r_sign_big, r_eff_sub, r_exp_no_dif, r_mant_no_dif, r_is_nan, r_is_inf;

  unpacked_t         w_a, w_b;
  logic              w_b_big, w_sign_b_eff, w_big_sign, w_eff_sub;
  logic [EXP_W-1:0]  w_big_exp, w_small_exp;
  logic [N-1:0]      w_big_mant, w_small_mant;
  logic [EXP_W:0]    w_diff;
  logic [CNT_W-1:0]  w_count;
  logic              w_a_ones, w_b_ones, w_a_frac_nz, w_b_frac_nz;
  logic              w_is_nan, w_is_inf, w_special, w_last;

  assign w_a          = unpack(r_op_a);
  assign w_b          = unpack(r_op_b);
  assign w_b_big      = {w_b.exp, w_b.mant} > {w_a.exp, w_a.mant};
  assign w_big_exp    = w_b_big ? w_b.exp  : w_a.exp;
  assign w_big_mant   = w_b_big ? w_b.mant : w_a.mant;
  assign w_small_exp  = w_b_big ? w_a.exp  : w_b.exp;
  assign w_small_mant = w_b_big ? w_a.mant : w_b.mant;

  // B's sign is taken as it enters the sum, i.e. flipped for subtraction.
  assign w_sign_b_eff = w_b.sign ^ r_sub;
  assign w_big_sign   = w_b_big ? w_sign_b_eff : w_a.sign;
  assign w_eff_sub    = w_a.sign ^ w_b.sign ^ r_sub;

  assign w_diff  = {1'b0, w_big_exp} - {1'b0, w_small_exp};
  assign w_count = (w_diff > (EXP_W+1)'(SHIFT_CAP)) ? CNT_W'(SHIFT_CAP) : w_diff[CNT_W-1:0];

  assign w_a_ones    = (r_op_a[OP_W-2 -: EXP_W] == EXP_ALL_ONES);
  assign w_b_ones    = (r_op_b[OP_W-2 -: EXP_W] == EXP_ALL_ONES);
  assign w_a_frac_nz = |r_op_a[N-2:0];
  assign w_b_frac_nz = |r_op_b[N-2:0];
  assign w_special   = w_a_ones | w_b_ones;
  assign w_is_nan    = (w_a_ones & w_a_frac_nz) | (w_b_ones & w_b_frac_nz) |
                       (w_a_ones & w_b_ones & ~w_a_frac_nz & ~w_b_frac_nz & w_eff_sub);
  assign w_is_inf    = ~w_is_nan & ((w_a_ones & ~w_a_frac_nz) | (w_b_ones & ~w_b_frac_nz));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_valid && r_ready) w_state_nxt = ST_UNPACK;
      ST_UNPACK: w_state_nxt = (w_special || w_count == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:   if (i_out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      if (r_state == ST_IDLE && i_valid && r_ready) begin
        r_op_a <= i_op_a;
        r_op_b <= i_op_b;
        r_sub  <= i_sub;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mant_big    <= '0;
      r_common_exp  <= '0;
      r_sign_big    <= 1'b0;
      r_eff_sub     <= 1'b0;
      r_exp_no_dif  <= 1'b0;
      r_mant_no_dif <= 1'b0;
      r_is_nan      <= 1'b0;
      r_is_inf      <= 1'b0;
    end else if (r_state == ST_UNPACK) begin
      r_mant_big    <= w_big_mant;
      r_common_exp  <= w_big_exp;
      r_sign_big    <= w_big_sign;
      r_eff_sub     <= w_eff_sub;
      r_exp_no_dif  <= (w_a.exp == w_b.exp);
      r_mant_no_dif <= (w_a.mant == w_b.mant);
      r_is_nan      <= w_is_nan;
      r_is_inf      <= w_is_inf;
    end
  end

  float_sticky_shifter u_shifter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (r_state == ST_UNPACK),
    .i_shift (r_state == ST_SHIFT),
    .i_mant  (w_small_mant),
    .i_count (w_count),
    .o_mant  (o_mant_small),
    .o_g     (o_g),
    .o_r     (o_r),
    .o_s     (o_s),
    .o_last  (w_last)
  );

  assign o_ready       = r_ready;
  assign o_valid       = (r_state == ST_DONE);
  assign o_mant_big    = r_mant_big;
  assign o_common_exp  = r_common_exp;
  assign o_sign_big    = r_sign_big;
  assign o_eff_sub     = r_eff_sub;
  assign o_exp_no_dif  = r_exp_no_dif;
  assign o_mant_no_dif = r_mant_no_dif;
  assign o_is_nan      = r_is_nan;
  assign o_is_inf      = r_is_inf;
  assign o_state       = r_state;

endmodule

// File: tb/tb_float_align.sv
// Self-checking bench for float_align: directed cases, random operands against an
// arithmetic reference model, backpressure, reset mid-shift and back-to-back transfers.
module tb_float_align;

  typedef struct packed {
    logic [23:0] mant_big;
    logic [23:0] mant_small;
    logic        g, r, s;
    logic [7:0]  common_exp;
    logic        sign_big, eff_sub, exp_no_dif, mant_no_dif, is_nan, is_inf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        sub_in = 1'b0, valid_in = 1'b0, out_ready = 1'b0;
  logic        ready, valid_out, g, r, s, sign_big, eff_sub, exp_no_dif, mant_no_dif, is_nan, is_inf;
  logic [23:0] mant_big, mant_small;
  logic [7:0]  common_exp;
  logic [1:0]  state;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  int   lat_q[$];

  float_align dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_a(op_a), .i_op_b(op_b), .i_sub(sub_in),
    .i_valid(valid_in), .o_ready(ready), .i_out_ready(out_ready), .o_valid(valid_out),
    .o_mant_big(mant_big), .o_mant_small(mant_small), .o_g(g), .o_r(r), .o_s(s),
    .o_common_exp(common_exp), .o_sign_big(sign_big), .o_eff_sub(eff_sub),
    .o_exp_no_dif(exp_no_dif), .o_mant_no_dif(mant_no_dif), .o_is_nan(is_nan),
    .o_is_inf(is_inf), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic res_t grab();
    res_t o;
    o.mant_big = mant_big;  o.mant_small = mant_small;
    o.g = g;  o.r = r;  o.s = s;
    o.common_exp = common_exp;  o.sign_big = sign_big;  o.eff_sub = eff_sub;
    o.exp_no_dif = exp_no_dif;  o.mant_no_dif = mant_no_dif;
    o.is_nan = is_nan;  o.is_inf = is_inf;
    return o;
  endfunction

  // Reference: treat mantissas as integers, scale the smaller by 4 (G,R slots),
  // divide by 2^shift and call any remainder sticky.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 output int lat);
    res_t   m;
    int     ea, eb, eea, eeb, big_e, small_e, c;
    longint ma, mb, mbig, msmall, ext, sh;
    bit     a_big, nan_a, nan_b, inf_a, inf_b, sb_eff, special;
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    eea = (ea == 0) ? 1 : ea;
    eeb = (eb == 0) ? 1 : eb;
    ma = longint'(a[22:0]) + ((ea == 0) ? 0 : 8388608);
    mb = longint'(b[22:0]) + ((eb == 0) ? 0 : 8388608);
    a_big = (longint'(eea) * 16777216 + ma) >= (longint'(eeb) * 16777216 + mb);
    big_e = a_big ? eea : eeb;   small_e = a_big ? eeb : eea;
    mbig  = a_big ? ma : mb;     msmall  = a_big ? mb : ma;
    special = (ea == 255) || (eb == 255);
    c = big_e - small_e;
    if (c > 26) c = 26;
    if (special) c = 0;
    ext = msmall * 4;
    sh  = ext >> c;
    m.mant_big   = 24'(mbig);
    m.mant_small = sh[25:2];
    m.g = sh[1];
    m.r = sh[0];
    m.s = (ext - (sh << c)) != 0;
    m.common_exp = 8'(big_e);
    m.eff_sub = a[31] ^ b[31] ^ sub;
    sb_eff = b[31] ^ sub;
    nan_a = (ea == 255) && (a[22:0] != 0);  inf_a = (ea == 255) && (a[22:0] == 0);
    nan_b = (eb == 255) && (b[22:0] != 0);  inf_b = (eb == 255) && (b[22:0] == 0);
    m.is_nan = nan_a || nan_b || (inf_a && inf_b && m.eff_sub);
    m.is_inf = !m.is_nan && (inf_a || inf_b);
    if (m.is_inf) m.sign_big = inf_a ? a[31] : sb_eff;
    else          m.sign_big = a_big ? a[31] : sb_eff;
    m.exp_no_dif  = (eea == eeb);
    m.mant_no_dif = (ma == mb);
`ifdef FLOAT_ALIGN_BARREL_EN
    lat = (c > 0) ? 3 : 2;
`else
    lat = 2 + c;
`endif
    return m;
  endfunction

  // Drivers: call at least #1 after a posedge; returns #1 after the transfer edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output bit ok);
    int n = 0;
    int lat;
    res_t m;
    while (!ready && n < 60) begin @(negedge clk); n++; end
    ok = ready;
    if (!ok) return;
    m = model(a, b, sub, lat);
    exp_q.push_back(m);
    lat_q.push_back(lat);
    op_a = a;  op_b = b;  sub_in = sub;  valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;  op_a = $urandom;  op_b = $urandom;  sub_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!valid_out && lat < 100);
    ok = valid_out;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_compare(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    bit   ok;
    int   lat, exp_lat;
    res_t obs, exp_r;
    start_op(a, b, sub, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s ready_timeout ready=%b required=1", name, ready); return; end
    wait_valid(lat, ok);
    exp_r = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL %s valid_timeout a=%h b=%h", name, a, b); return; end
    obs = grab();
    checks++;
    if (obs !== exp_r) begin
      failures++;
      $display("FAIL %s fields a=%h b=%h sub=%b got=%h required=%h", name, a, b, sub, obs, exp_r);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency a=%h b=%h got=%0d required=%0d", name, a, b, lat, exp_lat);
    end
    finish_op();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op_a = $urandom;  op_b = $urandom;  valid_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({grab(), ready, valid_out, state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h ready=%b valid=%b state=%0d required=0", grab(), ready, valid_out, state);
    end
    valid_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b required ready=1 valid=0", ready, valid_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h7FC00000,
                            32'h7F800000, 32'h7F800000, 32'h00000001, 32'h00000003, 32'h7F7FFFFF};
    logic [31:0] vb[10] = '{32'h3F800000, 32'h3E800000, 32'h33800001, 32'hC0000000, 32'h3F800000,
                            32'hFF800000, 32'h3F800000, 32'h00400000, 32'h3F800000, 32'h00000001};
    logic        vs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run_and_compare($sformatf("directed%0d", i), va[i], vb[i], vs[i]);
      if (i == 2) begin
        checks++;
        if ({mant_small, g, r, s} !== {24'h000000, 3'b101}) begin
          failures++;
          $display("FAIL directed_d24 got=%h/%b%b%b required=000000/101", mant_small, g, r, s);
        end
      end
    end
  endtask

  task automatic test_random();
    int ea, eb, mode;
    logic [31:0] a, b;
    for (int i = 0; i < 50; i++) begin
      mode = $urandom_range(0, 4);
      ea = $urandom_range(0, 254);
      case (mode)
        0: eb = $urandom_range(0, 255);
        1: eb = ea + $urandom_range(0, 30) - 15;
        2: eb = ea;
        3: eb = ea + (($urandom_range(0, 1) == 1) ? 1 : -1) * $urandom_range(23, 28);
        default: begin ea = 255; eb = $urandom_range(200, 255); end
      endcase
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (mode == 2 && $urandom_range(0, 2) == 0) b[22:0] = a[22:0];
      if (mode == 4 && $urandom_range(0, 1) == 0) a[22:0] = '0;
      if (mode == 4 && eb == 255 && $urandom_range(0, 1) == 0) b[22:0] = '0;
      run_and_compare($sformatf("random%0d", i), a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   lat;
    res_t snap, exp_r;
    start_op(32'h3F800000, 32'h3E800000, 1'b0, ok);
    wait_valid(lat, ok);
    exp_r = exp_q.pop_front();
    void'(lat_q.pop_front());
    checks++;
    if (!ok) begin failures++; $display("FAIL backpressure_valid_timeout valid=%b", valid_out); return; end
    snap = grab();
    checks++;
    if (snap !== exp_r) begin
      failures++;
      $display("FAIL backpressure_fields got=%h required=%h", snap, exp_r);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (grab() !== snap || valid_out !== 1'b1 || ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold got=%h valid=%b ready=%b required=%h valid=1 ready=0",
                 grab(), valid_out, ready, snap);
      end
    end
    finish_op();
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    start_op(32'h3F800000, 32'h33800001, 1'b0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL midshift_state got=%0d required=2", state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grab(), ready, valid_out, state} !== '0) begin
      failures++;
      $display("FAIL midshift_reset got=%h ready=%b valid=%b state=%0d required=0", grab(), ready, valid_out, state);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL midshift_ready got=%b required=1", ready);
    end
    @(posedge clk); #1;
    run_and_compare("after_reset", 32'h3F800000, 32'h3E800000, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_and_compare("b2b_first", 32'h40490FDB, 32'h3FC00000, 1'b1);
    checks++;
    if (ready !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle ready=%b valid=%b required ready=1 valid=0", ready, valid_out);
    end
    run_and_compare("b2b_second", 32'hC1200000, 32'h41200001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
